// File: rtl/bj_pkg.sv
// Shared branch/jump definitions: detect-unit encodings, 2-bit counter states
// and the predictor table entry layout.
package bj_pkg;

  localparam logic [2:0] BJ_BEQ  = 3'b000;
  localparam logic [2:0] BJ_BNE  = 3'b001;
  localparam logic [2:0] BJ_JUMP = 3'b011;
  localparam logic [2:0] BJ_BLT  = 3'b100;
  localparam logic [2:0] BJ_BGE  = 3'b101;
  localparam logic [2:0] BJ_BLTU = 3'b110;
  localparam logic [2:0] BJ_BGEU = 3'b111;

  typedef logic [1:0] ctr_t;

  localparam ctr_t SNT = 2'b00;
  localparam ctr_t WNT = 2'b01;
  localparam ctr_t WT  = 2'b10;
  localparam ctr_t ST  = 2'b11;

  // Entry fields are sized for the widest supported PC; narrower PCs zero-extend.
  localparam int unsigned BJ_PC_W  = 32;
  localparam int unsigned BJ_TAG_W = BJ_PC_W - 2;

  typedef struct packed {
    logic                valid;
    logic [BJ_TAG_W-1:0] tag;
    logic                uncond;
    ctr_t                ctr;
    logic [BJ_PC_W-1:0]  target;
  } bj_entry_t;

  localparam bj_entry_t BJ_ENTRY_RST = '{valid: 1'b0, tag: '0, uncond: 1'b0,
                                         ctr: WNT, target: '0};

endpackage

// File: rtl/bj_sat_counter.sv
// 2-bit saturating counter next-state; force_strong pins the state to strongly taken.
module bj_sat_counter
  import bj_pkg::*;
(
  input  ctr_t state,
  input  logic taken,
  input  logic force_strong,
  output ctr_t next_state
);

  always_comb begin
    next_state = state;
    if (force_strong) begin
      next_state = ST;
    end else if (taken) begin
      if (state != ST) next_state = state + 2'd1;
    end else begin
      if (state != SNT) next_state = state - 2'd1;
    end
  end

endmodule

// File: rtl/bj_predict.sv
// Direct-mapped fetch-side branch/jump predictor trained by EX resolutions.
// Optional BJ_PRED_STATS_EN adds saturating BRANCH_COUNT / MISS_COUNT outputs.
module bj_predict
  import bj_pkg::*;
#(
  parameter int unsigned IDX_W = 4,
  parameter int unsigned PC_W  = 32
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [PC_W-1:0] FETCH_PC,
  output logic            PRED_TAKEN,
  output logic [PC_W-1:0] PRED_TARGET,
  input  logic            EX_VALID,
  input  logic [2:0]      EX_BRANCH_JUMP,
  input  logic [PC_W-1:0] EX_PC,
  input  logic [PC_W-1:0] EX_TARGET,
  input  logic            EX_TAKEN,
  input  logic            EX_PRED_TAKEN,
  input  logic [PC_W-1:0] EX_PRED_TARGET,
`ifdef BJ_PRED_STATS_EN
  output logic [31:0]     BRANCH_COUNT,
  output logic [31:0]     MISS_COUNT,
`endif
  output logic            MISPREDICT,
  output logic [PC_W-1:0] REDIRECT_PC
);

  localparam int unsigned ENTRIES = 2 ** IDX_W;

  function automatic logic [BJ_TAG_W-1:0] tag_of(input logic [PC_W-1:0] pc);
    return BJ_TAG_W'(pc >> (IDX_W + 2));
  endfunction

  bj_entry_t       tbl_q [ENTRIES];
  bj_entry_t       tbl_d [ENTRIES];
  logic            mispredict_q, mispredict_d;
  logic [PC_W-1:0] redirect_q, redirect_d;

  // Lookup against registered table contents.
  logic [IDX_W-1:0] fetch_idx;
  bj_entry_t        fetch_entry;
  logic             fetch_hit;

  always_comb begin
    fetch_idx   = FETCH_PC[IDX_W+1:2];
    fetch_entry = tbl_q[fetch_idx];
    fetch_hit   = fetch_entry.valid && (fetch_entry.tag == tag_of(FETCH_PC));
    PRED_TAKEN  = fetch_hit && (fetch_entry.ctr[1] || fetch_entry.uncond);
    PRED_TARGET = PRED_TAKEN ? PC_W'(fetch_entry.target) : FETCH_PC + PC_W'(4);
  end

  // Training path; a miss is fed as WNT+taken so allocation lands on WT.
  logic [IDX_W-1:0] ex_idx;
  bj_entry_t        ex_entry;
  bj_entry_t        new_entry;
  logic             ex_hit;
  logic             is_jump;
  ctr_t             ctr_in;
  logic             taken_in;
  ctr_t             ctr_next;

  always_comb begin
    ex_idx   = EX_PC[IDX_W+1:2];
    ex_entry = tbl_q[ex_idx];
    ex_hit   = ex_entry.valid && (ex_entry.tag == tag_of(EX_PC));
    is_jump  = (EX_BRANCH_JUMP == BJ_JUMP);
    ctr_in   = ex_hit ? ex_entry.ctr : WNT;
    taken_in = EX_TAKEN || !ex_hit;
  end

  bj_sat_counter u_sat_counter (
    .state        (ctr_in),
    .taken        (taken_in),
    .force_strong (is_jump),
    .next_state   (ctr_next)
  );

  always_comb begin
    tbl_d        = tbl_q;
    new_entry    = ex_entry;
    mispredict_d = 1'b0;
    redirect_d   = redirect_q;
    if (EX_VALID) begin
      mispredict_d = (EX_TAKEN != EX_PRED_TAKEN) ||
                     (EX_TAKEN && (EX_PRED_TARGET != EX_TARGET));
      if (mispredict_d) redirect_d = EX_TAKEN ? EX_TARGET : EX_PC + PC_W'(4);
      if (ex_hit || EX_TAKEN) begin
        new_entry.valid  = 1'b1;
        new_entry.tag    = tag_of(EX_PC);
        new_entry.ctr    = ctr_next;
        new_entry.uncond = is_jump;
        if (EX_TAKEN) new_entry.target = BJ_PC_W'(EX_TARGET);
        tbl_d[ex_idx] = new_entry;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < int'(ENTRIES); i++) tbl_q[i] <= BJ_ENTRY_RST;
      mispredict_q <= 1'b0;
      redirect_q   <= '0;
    end else begin
      tbl_q        <= tbl_d;
      mispredict_q <= mispredict_d;
      redirect_q   <= redirect_d;
    end
  end

  // A reset arriving during the pulse cycle cancels the pending redirect.
  assign MISPREDICT  = mispredict_q && !RESET;
  assign REDIRECT_PC = redirect_q;

`ifdef BJ_PRED_STATS_EN
  logic [31:0] branch_count_q, branch_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  always_comb begin
    branch_count_d = branch_count_q;
    miss_count_d   = miss_count_q;
    if (EX_VALID && (branch_count_q != 32'hFFFF_FFFF)) branch_count_d = branch_count_q + 32'd1;
    if (mispredict_d && (miss_count_q != 32'hFFFF_FFFF)) miss_count_d = miss_count_q + 32'd1;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      branch_count_q <= '0;
      miss_count_q   <= '0;
    end else begin
      branch_count_q <= branch_count_d;
      miss_count_q   <= miss_count_d;
    end
  end

  assign BRANCH_COUNT = branch_count_q;
  assign MISS_COUNT   = miss_count_q;
`endif

endmodule

// File: tb/tb_bj_predict.sv
// Self-checking bench for bj_predict: directed scenarios plus randomized traffic
// checked every cycle against a table-level behavioural model.
module tb_bj_predict;

  localparam int unsigned IDX_W = 4;
  localparam int unsigned PC_W  = 32;

  localparam logic [2:0] E_BEQ  = 3'b000;
  localparam logic [2:0] E_BNE  = 3'b001;
  localparam logic [2:0] E_JUMP = 3'b011;

  logic            CLK = 1'b0;
  logic            RESET;
  logic [PC_W-1:0] FETCH_PC;
  logic            PRED_TAKEN;
  logic [PC_W-1:0] PRED_TARGET;
  logic            EX_VALID;
  logic [2:0]      EX_BRANCH_JUMP;
  logic [PC_W-1:0] EX_PC;
  logic [PC_W-1:0] EX_TARGET;
  logic            EX_TAKEN;
  logic            EX_PRED_TAKEN;
  logic [PC_W-1:0] EX_PRED_TARGET;
  logic            MISPREDICT;
  logic [PC_W-1:0] REDIRECT_PC;
`ifdef BJ_PRED_STATS_EN
  logic [31:0]     BRANCH_COUNT;
  logic [31:0]     MISS_COUNT;
`endif

  always #5 CLK = ~CLK;

  bj_predict #(.IDX_W(IDX_W), .PC_W(PC_W)) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .FETCH_PC       (FETCH_PC),
    .PRED_TAKEN     (PRED_TAKEN),
    .PRED_TARGET    (PRED_TARGET),
    .EX_VALID       (EX_VALID),
    .EX_BRANCH_JUMP (EX_BRANCH_JUMP),
    .EX_PC          (EX_PC),
    .EX_TARGET      (EX_TARGET),
    .EX_TAKEN       (EX_TAKEN),
    .EX_PRED_TAKEN  (EX_PRED_TAKEN),
    .EX_PRED_TARGET (EX_PRED_TARGET),
`ifdef BJ_PRED_STATS_EN
    .BRANCH_COUNT   (BRANCH_COUNT),
    .MISS_COUNT     (MISS_COUNT),
`endif
    .MISPREDICT     (MISPREDICT),
    .REDIRECT_PC    (REDIRECT_PC)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: 16 entries of plain integers, updated at each rising edge.
  bit              m_valid [16];
  int unsigned     m_tag   [16];
  bit              m_unc   [16];
  int              m_ctr   [16];
  logic [31:0]     m_tgt   [16];
  bit              m_mis;
  logic [31:0]     m_redir;
  longint unsigned m_bc, m_mc;
  bit              model_on = 1'b0;

  always @(posedge CLK) begin : model
    int unsigned i;
    bit hit;
    if (RESET) begin
      for (int k = 0; k < 16; k++) begin
        m_valid[k] = 1'b0; m_tag[k] = 0; m_unc[k] = 1'b0; m_ctr[k] = 1; m_tgt[k] = 32'h0;
      end
      m_mis = 1'b0; m_redir = 32'h0; m_bc = 0; m_mc = 0;
      model_on = 1'b1;
    end else begin
      m_mis = EX_VALID && ((EX_TAKEN != EX_PRED_TAKEN) ||
                           (EX_TAKEN && (EX_PRED_TARGET != EX_TARGET)));
      if (m_mis) m_redir = EX_TAKEN ? EX_TARGET : EX_PC + 32'd4;
      if (EX_VALID) begin
        if (m_bc < 64'hFFFF_FFFF) m_bc++;
        if (m_mis && m_mc < 64'hFFFF_FFFF) m_mc++;
        i   = (EX_PC / 4) % 16;
        hit = m_valid[i] && (m_tag[i] == EX_PC / 64);
        if (hit || EX_TAKEN) begin
          if (!hit) begin
            m_valid[i] = 1'b1; m_tag[i] = EX_PC / 64; m_ctr[i] = 2;
          end else if (EX_TAKEN) begin
            m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
          end else begin
            m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
          end
          if (EX_TAKEN) m_tgt[i] = EX_TARGET;
          if (EX_BRANCH_JUMP == E_JUMP) begin
            m_unc[i] = 1'b1; m_ctr[i] = 3;
          end else begin
            m_unc[i] = 1'b0;
          end
        end
      end
    end
  end

  // Every-cycle comparison, sampled mid-cycle on the falling edge.
  always @(negedge CLK) begin : compare
    int unsigned i;
    bit hit, pt, mis;
    if (model_on) begin
      i   = (FETCH_PC / 4) % 16;
      hit = m_valid[i] && (m_tag[i] == FETCH_PC / 64);
      pt  = hit && (m_ctr[i] >= 2 || m_unc[i]);
      mis = m_mis && !RESET;
      check("model_pred_taken", 32'(PRED_TAKEN), 32'(pt));
      check("model_pred_target", PRED_TARGET, pt ? m_tgt[i] : FETCH_PC + 32'd4);
      check("model_mispredict", 32'(MISPREDICT), 32'(mis));
      if (mis) check("model_redirect_pc", REDIRECT_PC, m_redir);
`ifdef BJ_PRED_STATS_EN
      if (!RESET) begin
        check("model_branch_count", BRANCH_COUNT, 32'(m_bc));
        check("model_miss_count", MISS_COUNT, 32'(m_mc));
      end
`endif
    end
  end

  task automatic ex(input logic [2:0] bj, input logic [31:0] pc, input logic [31:0] tgt,
                    input logic tk, input logic ptk, input logic [31:0] ptgt);
    @(posedge CLK); #1;
    EX_VALID = 1'b1; EX_BRANCH_JUMP = bj; EX_PC = pc; EX_TARGET = tgt;
    EX_TAKEN = tk; EX_PRED_TAKEN = ptk; EX_PRED_TARGET = ptgt;
  endtask

  task automatic idle();
    @(posedge CLK); #1;
    EX_VALID = 1'b0;
  endtask

  logic [2:0] encs [7] = '{3'b000, 3'b001, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};

  initial begin
    RESET = 1'b1; FETCH_PC = 32'h100; EX_VALID = 1'b0; EX_BRANCH_JUMP = E_BEQ;
    EX_PC = '0; EX_TARGET = '0; EX_TAKEN = 1'b0; EX_PRED_TAKEN = 1'b0; EX_PRED_TARGET = '0;
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);
    check("rst_pred_taken", 32'(PRED_TAKEN), 32'd0);
    check("rst_pred_target", PRED_TARGET, 32'h104);
    check("rst_mispredict", 32'(MISPREDICT), 32'd0);
    check("rst_redirect_pc", REDIRECT_PC, 32'h0);

    // First taken beq allocates and mispredicts.
    ex(E_BEQ, 32'h100, 32'h200, 1'b1, 1'b0, 32'h104);
    idle();
    @(negedge CLK);
    check("alloc_mispredict", 32'(MISPREDICT), 32'd1);
    check("alloc_redirect", REDIRECT_PC, 32'h200);
    check("alloc_pred_taken", 32'(PRED_TAKEN), 32'd1);
    check("alloc_pred_target", PRED_TARGET, 32'h200);

    // Two back-to-back not-taken resolutions: 10 -> 01 -> 00.
    ex(E_BEQ, 32'h100, 32'h200, 1'b0, 1'b1, 32'h200);
    ex(E_BEQ, 32'h100, 32'h200, 1'b0, 1'b1, 32'h200);
    @(negedge CLK);
    check("nt1_mispredict", 32'(MISPREDICT), 32'd1);
    check("nt1_redirect", REDIRECT_PC, 32'h104);
    check("nt1_pred_taken", 32'(PRED_TAKEN), 32'd0);
    idle();
    @(negedge CLK);
    check("nt2_mispredict", 32'(MISPREDICT), 32'd1);
    check("nt2_redirect", REDIRECT_PC, 32'h104);
    check("nt2_pred_target", PRED_TARGET, 32'h104);

    // Jump stays predicted taken through not-taken updates.
    ex(E_JUMP, 32'h300, 32'h40, 1'b1, 1'b0, 32'h304);
    repeat (4) ex(E_JUMP, 32'h300, 32'h40, 1'b0, 1'b1, 32'h40);
    idle();
    FETCH_PC = 32'h300;
    @(negedge CLK);
    check("jump_pred_taken", 32'(PRED_TAKEN), 32'd1);
    check("jump_pred_target", PRED_TARGET, 32'h40);

    // 0x140 aliases index 0 and replaces the entry.
    ex(E_BNE, 32'h140, 32'h500, 1'b1, 1'b0, 32'h144);
    idle();
    FETCH_PC = 32'h100;
    @(negedge CLK);
    check("alias_pred_taken", 32'(PRED_TAKEN), 32'd0);
    check("alias_pred_target", PRED_TARGET, 32'h104);
    #1 FETCH_PC = 32'h300;
    #1 check("alias_old_jump_gone", PRED_TARGET, 32'h304);
    #1 FETCH_PC = 32'h140;
    #1 check("alias_new_target", PRED_TARGET, 32'h500);

    // Reset in the pulse cycle cancels it and clears the table.
    ex(E_BEQ, 32'h180, 32'h600, 1'b1, 1'b0, 32'h184);
    @(posedge CLK); #1;
    EX_VALID = 1'b0; RESET = 1'b1;
    @(negedge CLK);
    check("rstcancel_mispredict", 32'(MISPREDICT), 32'd0);
    @(posedge CLK); #1;
    RESET = 1'b0;
    @(negedge CLK);
    check("rstcancel_pred_taken", 32'(PRED_TAKEN), 32'd0);
    check("rstcancel_mispredict2", 32'(MISPREDICT), 32'd0);
`ifdef BJ_PRED_STATS_EN
    check("rstcancel_branch_count", BRANCH_COUNT, 32'd0);
    check("rstcancel_miss_count", MISS_COUNT, 32'd0);
`endif

    // Randomized traffic over a small PC pool to force hits and aliasing.
    repeat (3000) begin
      @(posedge CLK); #1;
      RESET          = ($urandom_range(0, 199) == 0);
      EX_VALID       = ($urandom_range(0, 3) != 0);
      EX_BRANCH_JUMP = encs[$urandom_range(0, 6)];
      EX_PC          = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
      EX_TARGET      = $urandom_range(0, 255) << 2;
      EX_TAKEN       = (EX_BRANCH_JUMP == E_JUMP) ? ($urandom_range(0, 7) != 0)
                                                  : 1'($urandom_range(0, 1));
      EX_PRED_TAKEN  = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0:       EX_PRED_TARGET = EX_TARGET;
        1:       EX_PRED_TARGET = EX_PC + 32'd4;
        default: EX_PRED_TARGET = $urandom_range(0, 255) << 2;
      endcase
      FETCH_PC = ($urandom_range(0, 1) == 0) ? EX_PC
               : (($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2));
      if ($urandom_range(0, 63) == 0) FETCH_PC = 32'hFFFF_FFFC;
    end
    idle();
    RESET = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bj_predict.md
# bj_predict

Fetch-side branch/jump predictor paired with the EX-stage branch/jump detect unit: it predicts at fetch what the detect unit later resolves in EX, then reconciles the two. A direct-mapped table of 2-bit saturating counters with tags and targets drives next-PC selection in IF. Resolved outcomes from EX train the table. A registered mispredict/redirect pulse flushes IF/ID and steers the PC mux.

## Interface
- IDX_W, 4, table index width (2**IDX_W entries)
- PC_W, 32, PC width

- CLK  in  1  clock
- RESET  in  1  synchronous, active-high reset
- FETCH_PC  in  PC_W  PC being fetched this cycle
- PRED_TAKEN  out  1  prediction for FETCH_PC (combinational from table state)
- PRED_TARGET  out  PC_W  predicted next PC (target if taken, else FETCH_PC+4)
- EX_VALID  in  1  a branch/jump instruction is resolved in EX this cycle
- EX_BRANCH_JUMP  in  3  branch/jump encoding of that instruction (000 beq, 001 bne, 011 jump, 100 blt, 101 bge, 110 bltu, 111 bgeu)
- EX_PC  in  PC_W  PC of the resolving instruction
- EX_TARGET  in  PC_W  computed target
- EX_TAKEN  in  1  PC_SEL_OUT from the detect unit
- EX_PRED_TAKEN  in  1  prediction carried down the pipe with the instruction
- EX_PRED_TARGET  in  PC_W  predicted next PC carried down the pipe
- MISPREDICT  out  1  registered one-cycle flush/redirect pulse
- REDIRECT_PC  out  PC_W  corrected PC, valid while MISPREDICT=1

## Operation
- Entry: valid, tag = PC[PC_W-1:IDX_W+2], uncond bit, 2-bit counter, target. Index = PC[IDX_W+1:2].
- Lookup: hit = valid & tag match. PRED_TAKEN = hit & (counter[1] | uncond). PRED_TARGET = PRED_TAKEN ? entry target : FETCH_PC+4, modulo 2**PC_W.
- Update on EX_VALID, at the rising CLK edge:
  - Hit: counter saturating +1 if EX_TAKEN, else −1 (00 floor, 11 ceiling).
  - Hit and EX_TAKEN: target <= EX_TARGET.
  - Miss and EX_TAKEN: allocate (overwrite) with valid=1, tag, target. Counter = 10; uncond=0.
  - Miss and not taken: no change.
  - EX_BRANCH_JUMP=011: entry forced to uncond=1, counter=11.
  - Any other encoding: uncond=0.
- Mispredict = EX_VALID & ((EX_TAKEN != EX_PRED_TAKEN) | (EX_TAKEN & EX_PRED_TARGET != EX_TARGET)).
- On mispredict, REDIRECT_PC <= EX_TAKEN ? EX_TARGET : EX_PC+4.
- MISPREDICT is 0 whenever EX_VALID=0.
- Reset: all valid=0, counters=01, uncond=0, targets=0; MISPREDICT=0, REDIRECT_PC=0. PRED_TAKEN=0 and PRED_TARGET=FETCH_PC+4 from the first cycle after reset.

## Timing
- Lookup: zero-cycle, combinational on FETCH_PC against registered table.
- Update: visible to lookups starting the cycle after EX_VALID.
- Same-index lookup and update in one cycle: lookup returns pre-update contents.
- MISPREDICT/REDIRECT_PC: asserted the cycle after EX_VALID, for exactly one cycle.
- Back-to-back mispredicts on consecutive cycles give back-to-back pulses, each with its own REDIRECT_PC.
- RESET has priority over every update. RESET asserted while a mispredict pulse is pending cancels it.

## Configuration
- BJ_PRED_STATS_EN defined: adds outputs BRANCH_COUNT[31:0] and MISS_COUNT[31:0].
  - BRANCH_COUNT increments on every EX_VALID; MISS_COUNT increments on every mispredict.
  - Both saturate at 32'hFFFFFFFF and reset to 0.
  - Same one-cycle latency as MISPREDICT.
- Undefined: ports and counters absent; prediction behaviour identical.

## Structure
- Shared package bj_pkg holds:
  - branch/jump encoding constants (BJ_BEQ=3'b000 … BJ_BGEU=3'b111, BJ_JUMP=3'b011), also used by the detect unit;
  - counter state constants (SNT=00, WNT=01, WT=10, ST=11);
  - entry struct typedef.
- One sub-module: bj_sat_counter (2-bit saturating update: inputs state, taken, force_strong; output next state).

## Test plan
- Reset, FETCH_PC=0x100 -> PRED_TAKEN=0, PRED_TARGET=0x104; MISPREDICT=0.
- EX_VALID, beq, EX_PC=0x100, EX_TAKEN=1, EX_TARGET=0x200, EX_PRED_TAKEN=0 -> next cycle MISPREDICT=1, REDIRECT_PC=0x200. Then FETCH_PC=0x100 -> PRED_TAKEN=1, PRED_TARGET=0x200.
- Same branch resolved not-taken twice -> counter 10→01→00; PRED_TAKEN=0. Each resolution with EX_PRED_TAKEN=1 yields MISPREDICT with REDIRECT_PC=0x104.
- Jump (011) at 0x300 to 0x40, then four not-taken updates -> uncond stays 1, PRED_TAKEN=1, PRED_TARGET=0x40.
- Aliasing: taken branch at 0x140 (same index as 0x100, IDX_W=4) -> entry replaced; FETCH_PC=0x100 misses, PRED_TARGET=0x104.
- Mispredict resolved with RESET asserted in the following cycle -> MISPREDICT stays 0, table cleared. With BJ_PRED_STATS_EN defined, BRANCH_COUNT and MISS_COUNT read 0.
